// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time and
// presents fetched instructions to decode, discarding responses made stale by redirects.
`ifndef PC_RST_ADDR
`define PC_RST_ADDR 32'h0000_0000
`endif

module fetch_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [AW-1:0] RST_ADDR = `PC_RST_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [AW-1:0] if_pc,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc_plus4
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, DRAIN, HOLD} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr_buf;
  logic [AW-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~(AW'(3));

  // Redirect outranks every other event; DRAIN swallows the one response still owed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RST_ADDR;
      instr_buf <= '0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (redirect_valid) begin
            pc    <= redirect_aligned;
            state <= imem_req_ready ? DRAIN : REQ;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc    <= redirect_aligned;
            state <= imem_rsp_valid ? REQ : DRAIN;
          end else if (imem_rsp_valid) begin
            instr_buf <= imem_rsp_data;
            state     <= HOLD;
          end
        end
        DRAIN: begin
          if (redirect_valid) pc <= redirect_aligned;
          if (imem_rsp_valid) state <= REQ;
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_aligned;
            state <= REQ;
          end else if (if_ready) begin
            pc    <= pc + AW'(4);
            state <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign if_valid       = (state == HOLD);
  assign if_pc          = pc;
  assign if_instr       = instr_buf;
  assign if_pc_plus4    = pc + AW'(4);

  // A response is only legal while one is outstanding (WAIT or DRAIN)
  rsp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (state == REQ || state == HOLD || state == BOOT))
  );

endmodule
